// File: rtl/alu_mc_sequencer_if.sv
// Memory-port bundle between the multi-cycle sequencer (master) and the memory (slave).
// Carries the request/ready handshake and the fetched instruction word.
interface alu_mc_sequencer_if #(
  parameter int unsigned D_WIDTH = 32
);
  logic               mem_req;
  logic               mem_we;
  logic               mem_ready;
  logic [D_WIDTH-1:0] instr;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready,
    input  instr
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready,
    output instr
  );
endinterface

// File: rtl/alu_mc_sequencer.sv
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ready memory port.
// Control outputs are decoded from registered state; only ir_we/pc_we/pcsrc see mem_ready/eq.
module alu_mc_sequencer #(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_mc_sequencer_if.master        bus,
  input  logic                      eq,
  output logic                      ir_we,
  output logic                      pc_we,
  output logic                      pcsrc,
  output logic                      alusrc,
  output logic [3:0]                aluctrl,
  output logic [2:0]                immsrc,
  output logic                      regwrite,
  output logic [1:0]                resultsrc,
  output logic                      illegal
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StTrap   = 3'd5;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [2:0]         state_q, state_d;
  logic               run_q;
  logic [D_WIDTH-1:0] instr_q;
  logic [6:0]         op_q;
  logic [2:0]         f3_q;
  logic               f7b5_q;
  logic [4:0]         rd_q;

  logic       mem_req, mem_we;
  logic [3:0] alu_ctrl_dec;
  logic       alu_src_dec;
  logic [2:0] imm_src_dec;
  logic       is_load, is_store, is_branch, is_jump, op_legal, branch_taken;

  logic unused_instr;
  assign unused_instr = ^{instr_q[D_WIDTH-1:31], instr_q[29:15]};

  assign is_load   = (op_q == OpLoad);
  assign is_store  = (op_q == OpStore);
  assign is_branch = (op_q == OpBranch);
  assign is_jump   = (op_q == OpJal) || (op_q == OpJalr);
  assign op_legal  = instr_q[6:0] inside {OpLoad, OpImm, OpAuipc, OpStore, OpReg, OpLui,
                                          OpBranch, OpJalr, OpJal};

  // BEQ/BGE/BGEU are taken on eq=0, the other three on eq=1.
  assign branch_taken = f3_q[2] ? (eq ^ f3_q[0]) : (eq ^ ~f3_q[0]);

  // ALU controls depend only on the decoded instruction; held from EXEC through WB.
  always_comb begin
    alu_ctrl_dec = 4'b0000;
    alu_src_dec  = 1'b1;
    imm_src_dec  = 3'd0;
    case (op_q)
      OpReg: begin
        alu_ctrl_dec = {f7b5_q, f3_q};
        alu_src_dec  = 1'b0;
      end
      OpImm:   alu_ctrl_dec = {(f3_q == 3'b101) & f7b5_q, f3_q};
      OpStore: imm_src_dec = 3'd1;
      OpBranch: begin
        alu_src_dec  = 1'b0;
        imm_src_dec  = 3'd2;
        alu_ctrl_dec = f3_q[2] ? {3'b001, f3_q[1]} : 4'b0100;
      end
      OpLui: begin
        alu_ctrl_dec = 4'b1111;
        imm_src_dec  = 3'd3;
      end
      OpAuipc: imm_src_dec = 3'd3;
      OpJal:   imm_src_dec = 3'd4;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pcsrc     = 1'b0;
    alusrc    = 1'b0;
    aluctrl   = 4'b0000;
    immsrc    = 3'd0;
    regwrite  = 1'b0;
    resultsrc = 2'd0;
    illegal   = 1'b0;
    // run_q keeps every output low for the first cycle out of reset.
    if (run_q) begin
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
        alusrc  = alu_src_dec;
        aluctrl = alu_ctrl_dec;
        immsrc  = imm_src_dec;
      end
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_we   = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: state_d = op_legal ? StExec : StTrap;
        StExec: begin
          if (is_branch) begin
            pc_we   = 1'b1;
            pcsrc   = branch_taken;
            state_d = StFetch;
          end else if (is_load || is_store) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (bus.mem_ready) begin
            pc_we   = is_store;
            state_d = is_store ? StFetch : StWb;
          end
        end
        StWb: begin
          regwrite  = (rd_q != 5'd0);
          resultsrc = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
          pc_we     = 1'b1;
          pcsrc     = is_jump;
          state_d   = StFetch;
        end
        StTrap:  illegal = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
      instr_q <= '0;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7b5_q  <= 1'b0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (ir_we) begin
        instr_q <= bus.instr;
      end
      if (state_q == StDecode) begin
        op_q   <= instr_q[6:0];
        f3_q   <= instr_q[14:12];
        f7b5_q <= instr_q[30];
        rd_q   <= instr_q[11:7];
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_sequencer.sv
// Directed bench for alu_mc_sequencer: hand-built RV32I words, expected controls per cycle.
module tb_alu_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       eq;
  logic       ir_we, pc_we, pcsrc, alusrc, regwrite, illegal;
  logic [3:0] aluctrl;
  logic [2:0] immsrc;
  logic [1:0] resultsrc;

  int n_vec = 0;
  int n_err = 0;

  alu_mc_sequencer_if bus ();

  alu_mc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .eq        (eq),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pcsrc     (pcsrc),
    .alusrc    (alusrc),
    .aluctrl   (aluctrl),
    .immsrc    (immsrc),
    .regwrite  (regwrite),
    .resultsrc (resultsrc),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {15'd0, bus.mem_req, bus.mem_we, ir_we, pc_we, pcsrc, alusrc, aluctrl, immsrc,
            regwrite, resultsrc, illegal};
  endfunction

  // Completes a zero-wait fetch from FETCH and leaves the DUT in EXEC.
  task automatic fetch_to_exec(input string tag, input logic [31:0] w);
    check({tag, "_fetch_req"}, {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ready = 1'b1;
    bus.instr     = w;
    #1;
    check({tag, "_ir_we"}, {31'd0, ir_we}, 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    bus.instr     = 32'd0;
    #1;
    check({tag, "_decode_idle"}, {30'd0, bus.mem_req, pc_we}, 32'd0);
    tick();
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic eq_in,
                        input logic [3:0] exp_ctrl, input logic exp_taken);
    fetch_to_exec(tag, {7'd0, 5'd2, 5'd1, f3, 5'd8, 7'b1100011});
    eq = eq_in;
    #1;
    check({tag, "_aluctrl"}, {28'd0, aluctrl}, {28'd0, exp_ctrl});
    check({tag, "_src_imm"}, {28'd0, alusrc, immsrc}, 32'd2);
    check({tag, "_pc"}, {30'd0, pc_we, pcsrc}, {30'd0, 1'b1, exp_taken});
    tick();
    eq = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst           = 1'b0;
    eq            = 1'b0;
    bus.mem_ready = 1'b0;
    bus.instr     = 32'd0;
    #12;
    check("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // SUB x3,x1,x2
    w = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    fetch_to_exec("sub", w);
    check("sub_exec", {27'd0, aluctrl, alusrc}, {27'd0, 4'b1000, 1'b0});
    check("sub_exec_pc", {31'd0, pc_we}, 32'd0);
    tick();
    check("sub_wb", {27'd0, regwrite, resultsrc, pc_we, pcsrc}, {27'd0, 1'b1, 2'd0, 1'b1, 1'b0});
    tick();

    branch("beq", 3'b000, 1'b0, 4'b0100, 1'b1);
    branch("bne", 3'b001, 1'b0, 4'b0100, 1'b0);
    branch("bltu", 3'b110, 1'b1, 4'b0011, 1'b1);
    branch("bge", 3'b101, 1'b1, 4'b0010, 1'b0);

    // LW x5,0(x1) with three wait cycles in MEM
    w = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    fetch_to_exec("lw", w);
    check("lw_exec", {24'd0, aluctrl, alusrc, immsrc}, {24'd0, 4'b0000, 1'b1, 3'd0});
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", {29'd0, bus.mem_req, bus.mem_we, pc_we}, 32'b100);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("lw_mem_done", {29'd0, bus.mem_req, bus.mem_we, pc_we}, 32'b100);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("lw_wb", {27'd0, regwrite, resultsrc, pc_we, pcsrc}, {27'd0, 1'b1, 2'd1, 1'b1, 1'b0});
    tick();

    // SW x2,0(x1)
    w = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
    fetch_to_exec("sw", w);
    check("sw_exec", {28'd0, alusrc, immsrc}, {28'd0, 1'b1, 3'd1});
    tick();
    check("sw_mem_wait", {29'd0, bus.mem_req, bus.mem_we, pc_we}, 32'b110);
    bus.mem_ready = 1'b1;
    #1;
    check("sw_mem_done", {28'd0, bus.mem_we, pc_we, pcsrc, regwrite}, 32'b1100);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("sw_back_fetch", {30'd0, bus.mem_req, bus.mem_we}, 32'b10);

    // SRAI x4,x1,3
    w = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd4, 7'b0010011};
    fetch_to_exec("srai", w);
    check("srai_exec", {27'd0, aluctrl, alusrc}, {27'd0, 4'b1101, 1'b1});
    tick();
    check("srai_wb", {30'd0, regwrite, pc_we}, 32'b11);
    tick();

    // ADDI x0,x1,5
    w = {12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011};
    fetch_to_exec("addi_x0", w);
    check("addi_x0_exec", {27'd0, aluctrl, alusrc}, {27'd0, 4'b0000, 1'b1});
    tick();
    check("addi_x0_wb", {30'd0, regwrite, pc_we}, 32'b01);
    tick();

    // JAL x1,0
    w = {20'd0, 5'd1, 7'b1101111};
    fetch_to_exec("jal", w);
    check("jal_exec", {24'd0, aluctrl, alusrc, immsrc}, {24'd0, 4'b0000, 1'b1, 3'd4});
    tick();
    check("jal_wb", {27'd0, regwrite, resultsrc, pc_we, pcsrc}, {27'd0, 1'b1, 2'd2, 1'b1, 1'b1});
    tick();

    // Reset while a load sits in MEM
    w = {12'd4, 5'd1, 3'b010, 5'd6, 7'b0000011};
    fetch_to_exec("rst_lw", w);
    tick();
    check("rst_lw_in_mem", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_mem_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_resume_fetch", {30'd0, bus.mem_req, bus.mem_we}, 32'b10);

    // Unsupported opcode 0x7F traps until reset
    fetch_to_exec("trap", 32'h0000_007F);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("trap_hold", {29'd0, illegal, bus.mem_req, pc_we}, 32'b100);
      tick();
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("trap_cleared", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("trap_exit_fetch", {30'd0, bus.mem_req, illegal}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
